// File: rtl/button_event_decoder.sv
// button_event_decoder
//
// Turns the debounced, clk-synchronous button level into one-cycle user
// events (press, release, short press, long press, auto-repeat) and keeps
// the image-filter mode selection. A short press steps to the next mode and
// a long press returns to mode 0.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   btn_level      debounced button level, active high, synchronous to clk
//   press_pulse    one-cycle strobe on press
//   release_pulse  one-cycle strobe on release
//   short_press    one-cycle strobe on release before the long threshold
//   long_press     one-cycle strobe when the long-press threshold is reached
//   repeat_pulse   one-cycle strobe every REPEAT_TICKS after a long press
//   held           high while the button is held (PRESSED or LONG_HELD)
//   mode_sel       current filter mode, 0..NUM_MODES-1
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_WAIT_REL  | after reset; waits for the button to be seen released
// ST_IDLE      | button released, waiting for a press
// ST_PRESSED   | button held, counting towards the long-press threshold
// ST_LONG_HELD | long press recognised, counting auto-repeat periods
//
// Every output is registered, so a strobe appears the cycle after the
// btn_level sample that causes it.

module button_event_decoder #(
    parameter int unsigned CLOCK_FREQ_HZ = 100_000_000,
    parameter int unsigned LONG_PRESS_MS = 1000,
    parameter int unsigned REPEAT_MS     = 200,
    parameter int unsigned NUM_MODES     = 8,
    localparam int unsigned MODE_BITS    = $clog2(NUM_MODES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_level,
    output logic                 press_pulse,
    output logic                 release_pulse,
    output logic                 short_press,
    output logic                 long_press,
    output logic                 repeat_pulse,
    output logic                 held,
    output logic [MODE_BITS-1:0] mode_sel
);

    localparam int unsigned TICKS_PER_MS = CLOCK_FREQ_HZ / 1000;
    localparam int unsigned LONG_TICKS   = LONG_PRESS_MS * TICKS_PER_MS;
    localparam int unsigned REPEAT_TICKS = REPEAT_MS * TICKS_PER_MS;
    localparam int unsigned MAX_TICKS    = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int unsigned CNT_BITS     = $clog2(MAX_TICKS);

    localparam logic [CNT_BITS-1:0]  LONG_TC   = CNT_BITS'(LONG_TICKS - 1);
    localparam logic [CNT_BITS-1:0]  REPEAT_TC = CNT_BITS'(REPEAT_TICKS - 1);
    localparam logic [MODE_BITS-1:0] MODE_LAST = MODE_BITS'(NUM_MODES - 1);

    // ST_WAIT_REL must encode as 0 so the whole block resets to zero.
    typedef enum logic [1:0] {
        ST_WAIT_REL  = 2'd0,
        ST_IDLE      = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_LONG_HELD = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [MODE_BITS-1:0] mode_q, mode_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 short_q, short_d;
    logic                 long_q, long_d;
    logic                 repeat_q, repeat_d;
    logic                 held_q, held_d;
    logic [MODE_BITS-1:0] mode_next;

    // Explicit wrap so non-power-of-two mode counts cycle correctly.
    assign mode_next = (mode_q == MODE_LAST) ? '0 : mode_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            ST_WAIT_REL: begin
                if (!btn_level) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (btn_level) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_PRESSED: begin
                // Release is tested first so it wins over the threshold.
                if (!btn_level) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    mode_d    = mode_next;
                end else if (cnt_q == LONG_TC) begin
                    state_d = ST_LONG_HELD;
                    long_d  = 1'b1;
                    mode_d  = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (!btn_level) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end else if (cnt_q == REPEAT_TC) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_REL;
            end
        endcase

        // Registered from the next state so held rises with press_pulse
        // and falls with release_pulse.
        held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG_HELD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_WAIT_REL;
            cnt_q     <= '0;
            mode_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_press   = short_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;
    assign mode_sel      = mode_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_TICKS=10, REPEAT_TICKS=4,
// NUM_MODES=5. Inputs change 1 time unit after a rising edge and outputs are
// checked 1 time unit after the edge that sampled them.

module tb_button_event_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_level;
    logic       press_pulse, release_pulse, short_press, long_press, repeat_pulse, held;
    logic [2:0] mode_sel;

    int n_total = 0;
    int n_bad   = 0;
    int exp_mode;

    // Event vector order: {press, release, short, long, repeat, held}
    localparam logic [5:0] EV_NONE  = 6'b000000;
    localparam logic [5:0] EV_PRESS = 6'b100001;
    localparam logic [5:0] EV_HELD  = 6'b000001;
    localparam logic [5:0] EV_SHORT = 6'b011000;
    localparam logic [5:0] EV_REL   = 6'b010000;
    localparam logic [5:0] EV_LONG  = 6'b000101;
    localparam logic [5:0] EV_REP   = 6'b000011;

    button_event_decoder #(
        .CLOCK_FREQ_HZ(1000),
        .LONG_PRESS_MS(10),
        .REPEAT_MS    (4),
        .NUM_MODES    (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .mode_sel     (mode_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_ev(input string tag, input logic [5:0] ev, input int mode);
        chk({tag, ".ev"}, {26'd0, press_pulse, release_pulse, short_press,
                           long_press, repeat_pulse, held}, {26'd0, ev});
        chk({tag, ".mode"}, {29'd0, mode_sel}, mode);
    endtask

    task automatic cyc(input logic b);
        btn_level = b;
        @(posedge clk);
        #1;
    endtask

    function automatic int adv(input int m);
        return (m == 4) ? 0 : m + 1;
    endfunction

    task automatic short_cycle(input string tag);
        cyc(1'b1); expect_ev({tag, ".press"}, EV_PRESS, exp_mode);
        cyc(1'b1); expect_ev({tag, ".hold"}, EV_HELD, exp_mode);
        exp_mode = adv(exp_mode);
        cyc(1'b0); expect_ev({tag, ".rel"}, EV_SHORT, exp_mode);
        cyc(1'b0); expect_ev({tag, ".idle"}, EV_NONE, exp_mode);
    endtask

    initial begin
        reset     = 1'b1;
        btn_level = 1'b0;
        exp_mode  = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_ev("reset", EV_NONE, 0);
        reset = 1'b0;
        cyc(1'b0); expect_ev("wait_to_idle", EV_NONE, 0);

        // Short press: 3 high samples then low.
        cyc(1'b1); expect_ev("sp.press", EV_PRESS, 0);
        cyc(1'b1); expect_ev("sp.h1", EV_HELD, 0);
        cyc(1'b1); expect_ev("sp.h2", EV_HELD, 0);
        cyc(1'b0); expect_ev("sp.rel", EV_SHORT, 1);
        cyc(1'b0); expect_ev("sp.idle", EV_NONE, 1);
        exp_mode = 1;

        // Long press with repeats: 20 high samples, P is the press cycle.
        cyc(1'b1); expect_ev("lp.press", EV_PRESS, 1);
        for (int i = 1; i < 20; i++) begin
            cyc(1'b1);
            if (i == 10)
                expect_ev("lp.long", EV_LONG, 0);
            else if (i == 14 || i == 18)
                expect_ev("lp.rep", EV_REP, 0);
            else
                expect_ev("lp.hold", EV_HELD, (i > 10) ? 0 : 1);
        end
        cyc(1'b0); expect_ev("lp.rel", EV_REL, 0);
        cyc(1'b0); expect_ev("lp.idle", EV_NONE, 0);
        exp_mode = 0;

        // Wrap-around: 5 short presses visit 1,2,3,4,0.
        for (int k = 0; k < 5; k++) short_cycle("wrap");
        chk("wrap.final", {29'd0, mode_sel}, 0);

        // Advance to mode 3, then a long press forces 0.
        for (int k = 0; k < 3; k++) short_cycle("to3");
        chk("to3.mode", {29'd0, mode_sel}, 3);
        cyc(1'b1); expect_ev("l3.press", EV_PRESS, 3);
        for (int i = 1; i < 10; i++) begin
            cyc(1'b1); expect_ev("l3.hold", EV_HELD, 3);
        end
        cyc(1'b1); expect_ev("l3.long", EV_LONG, 0);
        cyc(1'b0); expect_ev("l3.rel", EV_REL, 0);
        cyc(1'b0); expect_ev("l3.idle", EV_NONE, 0);

        // Boundary: first low sample when counter==9 gives short press,
        // then an immediate re-press after one IDLE cycle.
        cyc(1'b1); expect_ev("bd.press", EV_PRESS, 0);
        for (int i = 1; i < 10; i++) begin
            cyc(1'b1); expect_ev("bd.hold", EV_HELD, 0);
        end
        cyc(1'b0); expect_ev("bd.short", EV_SHORT, 1);
        cyc(1'b1); expect_ev("bd.repress", EV_PRESS, 1);
        cyc(1'b0); expect_ev("bd.rel2", EV_SHORT, 2);
        cyc(1'b0); expect_ev("bd.idle", EV_NONE, 2);

        // Reset mid-LONG_HELD, while repeat_pulse is high.
        cyc(1'b1); expect_ev("rs.press", EV_PRESS, 2);
        for (int i = 1; i < 15; i++) begin
            cyc(1'b1);
            if (i == 10)      expect_ev("rs.long", EV_LONG, 0);
            else if (i == 14) expect_ev("rs.rep", EV_REP, 0);
        end
        #2 reset = 1'b1;
        #1 expect_ev("rs.async", EV_NONE, 0);
        cyc(1'b1); expect_ev("rs.in_reset", EV_NONE, 0);
        reset = 1'b0;

        // Button still held after reset: no strobes, no release.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1); expect_ev("hr.held", EV_NONE, 0);
        end
        cyc(1'b0); expect_ev("hr.release", EV_NONE, 0);
        cyc(1'b1); expect_ev("hr.press", EV_PRESS, 0);
        cyc(1'b0); expect_ev("hr.short", EV_SHORT, 1);
        cyc(1'b0); expect_ev("hr.idle", EV_NONE, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Converts the clean, clock-synchronous level from the button debouncer into single-cycle user events: press, release, short press, long press, and auto-repeat while held. It also keeps the image-filter mode selection: a short press steps to the next mode and a long press returns to mode 0. It sits directly downstream of the debouncer and feeds mode/event strobes to the processing control logic.

## Interface
Parameters:
- CLOCK_FREQ_HZ, 100_000_000: system clock frequency in Hz.
- LONG_PRESS_MS, 1000: hold time that qualifies a long press.
- REPEAT_MS, 200: auto-repeat period once a long press is recognised.
- NUM_MODES, 8: number of filter modes (must be ≥2).

Derived constants:
- LONG_TICKS = LONG_PRESS_MS*(CLOCK_FREQ_HZ/1000), must be ≥2.
- REPEAT_TICKS = REPEAT_MS*(CLOCK_FREQ_HZ/1000), must be ≥1.
- MODE_BITS = $clog2(NUM_MODES).
- CNT_BITS = $clog2(max(LONG_TICKS, REPEAT_TICKS)).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_level  in  1  debounced button level, already synchronous to clk, active high.
- press_pulse  out  1  one-cycle strobe when the button is pressed.
- release_pulse  out  1  one-cycle strobe when the button is released.
- short_press  out  1  one-cycle strobe on release before the long-press threshold.
- long_press  out  1  one-cycle strobe when the long-press threshold is reached.
- repeat_pulse  out  1  one-cycle strobe every REPEAT_TICKS after a long press.
- held  out  1  high while the FSM is in PRESSED or LONG_HELD.
- mode_sel  out  MODE_BITS  current filter mode, range 0..NUM_MODES-1.

## Operation
- All outputs are registered. Every output and internal register resets to 0.
- FSM states: WAIT_RELEASE (reset state), IDLE, PRESSED, LONG_HELD.
- WAIT_RELEASE:
  - Stays here while btn_level=1, so a button held through reset produces no event.
  - Moves to IDLE when btn_level=0 is sampled; no event is generated.
- IDLE:
  - btn_level=1 → PRESSED, press_pulse, counter cleared.
- PRESSED:
  - btn_level=0 → IDLE, release_pulse and short_press, mode_sel advances.
  - Otherwise, if counter==LONG_TICKS-1 → LONG_HELD, long_press, mode_sel←0, counter cleared.
  - Otherwise counter increments.
- LONG_HELD:
  - btn_level=0 → IDLE, release_pulse only; no short_press.
  - Otherwise, if counter==REPEAT_TICKS-1 → repeat_pulse, counter cleared.
  - Otherwise counter increments.
- mode_sel arithmetic:
  - Advance means mode_sel+1, wrapping NUM_MODES-1 → 0.
  - This wrap applies even when NUM_MODES is not a power of 2.
  - mode_sel changes on the same edge that asserts short_press or long_press.
- Repeat pulses never change mode_sel.
- Release has priority: btn_level=0 on the cycle the counter reaches its terminal value gives short_press (PRESSED) or release only (LONG_HELD). No long_press or repeat_pulse is generated on that cycle.

## Timing
- Latency: each strobe is high for exactly 1 cycle, on the edge after the causing btn_level sample.
- Let P be the cycle press_pulse is high:
  - long_press is high at cycle P+LONG_TICKS.
  - The k-th repeat_pulse is high at cycle P+LONG_TICKS+k*REPEAT_TICKS.
- held rises with press_pulse and falls with release_pulse.
- A release followed by a press needs at least 1 cycle in IDLE. btn_level=0 for one cycle, then 1, gives release_pulse then press_pulse on consecutive cycles.
- Reset asserted mid-press:
  - All outputs clear immediately (asynchronously) and mode_sel returns to 0.
  - No release_pulse is generated.
  - After reset deasserts, the FSM waits in WAIT_RELEASE.
- At most one of press_pulse, long_press, or repeat_pulse is high in any cycle. release_pulse and short_press assert together.

## Test plan
Benches use CLOCK_FREQ_HZ=1000, LONG_PRESS_MS=10, REPEAT_MS=4, NUM_MODES=5, so LONG_TICKS=10 and REPEAT_TICKS=4.
- Short press: btn_level high for 3 cycles, then low → press_pulse once, then release_pulse and short_press together, mode_sel 0→1; long_press never asserts.
- Long press with repeat: btn_level high for 20 cycles, press_pulse at P → long_press at P+10 with mode_sel=0, repeat_pulse at P+14 and P+18, release_pulse with no short_press.
- Wrap-around: 5 short presses → mode_sel goes 1,2,3,4,0; a long press at mode_sel=3 forces 0.
- Boundary: btn_level falls so the first low sample lands on the cycle where counter==9 → short_press, no long_press, mode_sel advances.
- Held through reset: btn_level=1 during and after reset release → no strobes until btn_level goes 0 and then 1 again; that second press gives a normal press_pulse.
- Reset mid-LONG_HELD: assert reset asynchronously → all outputs 0 within the same cycle, mode_sel=0, no release_pulse after reset.
